// File: rtl/uart_pkg.sv
// ============================================================
// Module : uart_pkg
// Shared UART receiver/transmitter state encoding and frame defaults.
// Rev    : 1.0
// ============================================================
`default_nettype none

package uart_pkg;

    localparam int c_data_bits_default  = 8;
    localparam int c_parity_en_default  = 0;
    localparam int c_parity_odd_default = 0;

    localparam logic [3:0] c_mid_tick  = 4'd7;
    localparam logic [3:0] c_last_tick = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    function automatic logic parity_of(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync.sv
// ============================================================
// Module : uart_sync
// Two-flop synchronizer for the idle-high serial line.
// Rev    : 1.0
// ============================================================
`default_nettype none

module uart_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], d};
        end
    end

    assign q = r_sync[1];

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================
// Module : uart_rx
// 16x-oversampled UART receiver with ready/valid output and error flags.
// Rev    : 1.0
// ============================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = c_data_bits_default,
    parameter int PARITY_EN  = c_parity_en_default,
    parameter int PARITY_ODD = c_parity_odd_default
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_x16_tick,
    input  logic       rx,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err
);

    localparam logic [2:0] c_last_bit = 3'(DATA_BITS - 1);
    localparam logic       c_odd      = (PARITY_ODD != 0);
    localparam logic       c_par_en   = (PARITY_EN != 0);

    logic        w_rx_s;
    uart_state_t r_state;
    logic [3:0]  r_tick_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_par_err;
    logic        r_stop_err;
    logic        r_frame_done;

    uart_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (w_rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_err    <= 1'b0;
            r_stop_err   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (baud_x16_tick) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_rx_s) begin
                            r_state    <= ST_START;
                            r_tick_cnt <= '0;
                        end
                    end
                    ST_START: begin
                        // Re-check mid start bit so short low glitches are ignored.
                        if (r_tick_cnt == c_mid_tick) begin
                            r_tick_cnt <= '0;
                            if (w_rx_s) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_state   <= ST_DATA;
                                r_bit_cnt <= '0;
                                r_shift   <= '0;
                                r_par_err <= 1'b0;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 4'd1;
                        end
                    end
                    ST_DATA: begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                        if (r_tick_cnt == c_last_tick) begin
                            r_shift[r_bit_cnt] <= w_rx_s;
                            r_bit_cnt          <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == c_last_bit) begin
                                r_state <= c_par_en ? ST_PARITY : ST_STOP;
                            end
                        end
                    end
                    ST_PARITY: begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                        if (r_tick_cnt == c_last_tick) begin
                            r_par_err <= (parity_of(r_shift) ^ w_rx_s) != c_odd;
                            r_state   <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                        if (r_tick_cnt == c_last_tick) begin
                            r_stop_err   <= ~w_rx_s;
                            r_frame_done <= 1'b1;
                            r_state      <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // A completed frame wins over a simultaneous handshake; it is dropped only if the slot stays occupied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (r_frame_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= r_shift;
                    parity_err <= r_par_err;
                    frame_err  <= r_stop_err;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================
// Module : tb_uart_rx
// Directed self-checking bench for uart_rx (8N1 and 8E1 instances).
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_uart_rx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       rx = 1'b1;
    logic       rx_p = 1'b1;
    logic       rx_ready = 1'b0;
    logic       ready_p = 1'b0;
    logic [1:0] div = 2'd0;

    logic [7:0] rx_data, rx_data_p;
    logic       rx_valid, parity_err, frame_err, overrun_err;
    logic       rx_valid_p, parity_err_p, frame_err_p, overrun_err_p;

    int n_checks = 0;
    int n_pass = 0;
    int ovr_total = 0;
    int data_cycles = 0;
    int base;
    bit hit;

    uart_rx dut (
        .clk (clk), .reset (reset), .baud_x16_tick (tick), .rx (rx),
        .rx_ready (rx_ready), .rx_data (rx_data), .rx_valid (rx_valid),
        .parity_err (parity_err), .frame_err (frame_err), .overrun_err (overrun_err)
    );

    uart_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_par (
        .clk (clk), .reset (reset), .baud_x16_tick (tick), .rx (rx_p),
        .rx_ready (ready_p), .rx_data (rx_data_p), .rx_valid (rx_valid_p),
        .parity_err (parity_err_p), .frame_err (frame_err_p), .overrun_err (overrun_err_p)
    );

    always #5 clk = ~clk;

    // Baud generator with divisor 4: one tick every fourth clock.
    always @(posedge clk) begin
        div  <= div + 2'd1;
        tick <= (div == 2'd3);
    end

    always @(negedge clk) begin
        if (overrun_err) ovr_total += 1;
        if (dut.r_state == ST_DATA) data_cycles += 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic hold_bit(input bit to_par, input logic v);
        if (to_par) rx_p = v;
        else        rx   = v;
        repeat (64) @(negedge clk);
    endtask

    task automatic send(input bit to_par, input logic [7:0] d, input bit pen,
                        input logic pbit, input logic stop);
        hold_bit(to_par, 1'b0);
        for (int i = 0; i < 8; i++) hold_bit(to_par, d[i]);
        if (pen) hold_bit(to_par, pbit);
        hold_bit(to_par, stop);
        hold_bit(to_par, 1'b1);
    endtask

    task automatic wait_valid(input string tag, input bit to_par);
        for (int i = 0; i < 400; i++) begin
            if (to_par ? rx_valid_p : rx_valid) break;
            @(negedge clk);
        end
        check({tag, "_valid"}, 32'(to_par ? rx_valid_p : rx_valid), 32'd1);
    endtask

    task automatic consume(input string tag);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check({tag, "_consumed"}, 32'(rx_valid), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'h00);
        check("rst_errs", 32'({parity_err, frame_err, overrun_err}), 32'd0);
        check("rst_valid_par", 32'(rx_valid_p), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        wait_valid("a5", 1'b0);
        check("a5_data", 32'(rx_data), 32'hA5);
        check("a5_errs", 32'({parity_err, frame_err}), 32'd0);
        consume("a5");

        base = data_cycles;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (256) @(negedge clk);
        check("glitch_data_state", 32'(data_cycles - base), 32'd0);
        check("glitch_valid", 32'(rx_valid), 32'd0);

        send(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
        wait_valid("par", 1'b1);
        check("par_data", 32'(rx_data_p), 32'h3C);
        check("par_perr", 32'(parity_err_p), 32'd1);
        check("par_ferr", 32'(frame_err_p), 32'd0);

        send(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        wait_valid("ferr", 1'b0);
        check("ferr_data", 32'(rx_data), 32'h55);
        check("ferr_flag", 32'(frame_err), 32'd1);
        consume("ferr");
        send(1'b0, 8'h0F, 1'b0, 1'b0, 1'b1);
        wait_valid("0f", 1'b0);
        check("0f_data", 32'(rx_data), 32'h0F);
        check("0f_ferr", 32'(frame_err), 32'd0);
        consume("0f");

        base = ovr_total;
        send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        send(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check("ovr_valid", 32'(rx_valid), 32'd1);
        check("ovr_data", 32'(rx_data), 32'h11);
        check("ovr_pulse_cycles", 32'(ovr_total - base), 32'd1);
        consume("ovr");

        send(1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
        check("hs_first_data", 32'(rx_data), 32'h33);
        base = ovr_total;
        hit = 1'b0;
        fork
            send(1'b0, 8'hC4, 1'b0, 1'b0, 1'b1);
            begin
                for (int i = 0; i < 2000; i++) begin
                    @(negedge clk);
                    if (dut.r_frame_done) begin
                        rx_ready = 1'b1;
                        @(negedge clk);
                        rx_ready = 1'b0;
                        hit = 1'b1;
                        break;
                    end
                end
            end
        join
        check("hs_seen_done", 32'(hit), 32'd1);
        check("hs_valid", 32'(rx_valid), 32'd1);
        check("hs_data", 32'(rx_data), 32'hC4);
        check("hs_no_overrun", 32'(ovr_total - base), 32'd0);

        hold_bit(1'b0, 1'b0);
        rx = 1'b1;
        repeat (4 * 64 + 20) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("mrst_valid", 32'(rx_valid), 32'd0);
        check("mrst_data", 32'(rx_data), 32'h00);
        check("mrst_errs", 32'({parity_err, frame_err, overrun_err}), 32'd0);
        reset = 1'b0;
        repeat (5 * 64) @(negedge clk);
        check("mrst_no_frame", 32'(rx_valid), 32'd0);
        send(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
        wait_valid("81", 1'b0);
        check("81_data", 32'(rx_data), 32'h81);
        check("81_errs", 32'({parity_err, frame_err}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter DATA_BITS, default 8, number of data bits per frame (5..8).
REQ-002 SHALL provide parameter PARITY_EN, default 0, 1 = parity bit expected after data.
REQ-003 SHALL provide parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
REQ-004 SHALL provide port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL provide port baud_x16_tick  input  1  single-clk strobe at 16x baud rate, from the baud generator.
REQ-007 SHALL provide port rx  input  1  serial line, asynchronous to clk, idle high.
REQ-008 SHALL provide port rx_ready  input  1  consumer accepts rx_data when high with rx_valid.
REQ-009 SHALL provide port rx_data  output  8  received byte, LSB-aligned, unused upper bits 0.
REQ-010 SHALL provide port rx_valid  output  1  rx_data and error flags valid.
REQ-011 SHALL provide port parity_err  output  1  parity mismatch on the held frame.
REQ-012 SHALL provide port frame_err  output  1  stop bit sampled low on the held frame.
REQ-013 SHALL provide port overrun_err  output  1  one-clk pulse, completed frame dropped.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP; tick counter 4 bits, bit counter 3 bits; counters advance only on baud_x16_tick.
REQ-016 IDLE: on a tick with synced rx=0, SHALL go to START with tick counter cleared.
REQ-017 START: on the 8th tick (counter=7), synced rx=1 SHALL return to IDLE (glitch rejected, no output); rx=0 SHALL clear counter and go to DATA.
REQ-018 DATA: on every 16th tick (counter=15) SHALL shift synced rx in LSB first; after DATA_BITS samples SHALL go to PARITY if PARITY_EN else STOP.
REQ-019 PARITY: on the 16th tick SHALL sample parity bit; parity_err = XOR(data, bit) != PARITY_ODD.
REQ-020 STOP: on the 16th tick (mid stop bit) SHALL sample; rx=0 sets frame_err; SHALL return to IDLE same cycle, permitting back-to-back frames.
REQ-021 SHALL assert rx_valid and load rx_data/parity_err/frame_err on the clk after the stop sample; frames with errors are still delivered.
REQ-022 SHALL hold rx_valid, rx_data and flags stable until a clk edge with rx_valid=1 and rx_ready=1, then clear rx_valid.
REQ-023 If a frame completes while rx_valid=1 and rx_ready=0, SHALL keep the old frame, drop the new one, pulse overrun_err for one clk.
REQ-024 If a frame completes in the same clk rx_valid&rx_ready handshakes, SHALL load the new frame with rx_valid remaining 1, no overrun.
REQ-025 SHALL ignore rx_ready when rx_valid=0; rx_valid never depends combinationally on rx_ready.

Reset
REQ-026 On reset SHALL force state IDLE, counters 0, synchronizer flops 1, rx_data 0, rx_valid 0, all error outputs 0.
REQ-027 Reset mid-frame SHALL abandon the frame with no output; reception resumes at the next falling edge after release.

Structure
REQ-028 Shared package uart_pkg SHALL hold the state enum and default DATA_BITS/parity constants, reused by the transmitter.
REQ-029 SHALL instantiate one sub-module uart_sync (2-flop synchronizer, reset value 1).

Verification
REQ-030 baud_gen divisor 4, 8N1, send 0xA5 -> rx_valid after stop mid-bit, rx_data=0xA5, no errors.
REQ-031 rx low for 4 ticks then high -> no state beyond START, rx_valid stays 0.
REQ-032 PARITY_EN=1, even, send 0x3C with parity bit 1 -> rx_data=0x3C, parity_err=1.
REQ-033 send 0x55 with stop bit 0 -> rx_data=0x55, frame_err=1, next frame 0x0F received cleanly.
REQ-034 rx_ready held 0, send 0x11 then 0x22 -> rx_data=0x11 held, one-clk overrun_err; then rx_ready=1 clears rx_valid.
REQ-035 reset asserted during data bit 4 of 0xFF -> all outputs 0; next frame 0x81 received correctly.
